spi_dac_receiver: RTL

// - SPI responder for the DAC link: the receiving end of the 16-bit write frames the DAC master emits.
// - Oversamples CS/SCK/SDI/LD on CLOCK_50, deserialises frames, checks the header, and presents the
//   10-bit DAC code plus config bits on an LD strobe.
// - Used as an on-chip loopback/DAC model, so the DAC/PWM path can be checked against the ROM output.

---
 rtl/spi_dac_receiver_pkg.sv | 45 ++++
 rtl/spi_edge_sync.sv | 37 +++
 rtl/spi_dac_receiver.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/spi_dac_receiver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_dac_receiver_pkg
// Description : Frame layout, FSM encodings and field decode for the DAC link.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_dac_receiver_pkg;

    localparam int c_frame_bits = 16;
    localparam int c_wr_n       = 15;
    localparam int c_buf        = 14;
    localparam int c_ga_n       = 13;
    localparam int c_shdn_n     = 12;
    localparam int c_data_msb   = 11;
    localparam int c_data_lsb   = 2;
    localparam int c_data_bits  = c_data_msb - c_data_lsb + 1;
    localparam int c_cnt_bits   = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic                   buffered;
        logic                   gain1x;
        logic                   shdn;
        logic [c_data_bits-1:0] value;
    } dac_cfg_t;

    localparam dac_cfg_t c_cfg_reset = '{buffered: 1'b0, gain1x: 1'b1, shdn: 1'b1, value: '0};

    // Control bits on the wire are active-low; shdn is presented active-high.
    function automatic dac_cfg_t decode_frame(input logic [c_buf:c_data_lsb] fields);
        dac_cfg_t cfg;
        cfg.buffered = fields[c_buf];
        cfg.gain1x   = fields[c_ga_n];
        cfg.shdn     = ~fields[c_shdn_n];
        cfg.value    = fields[c_data_msb:c_data_lsb];
        return cfg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : spi_edge_sync
// Description : Multi-flop synchroniser with registered rise/fall detection.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Reset to the idle bus level so release of reset never looks like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_dac_receiver.sv
`default_nettype none
// ============================================================================
// Module      : spi_dac_receiver
// Description : SPI responder that deserialises DAC write frames and latches them.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_dac_receiver
    import spi_dac_receiver_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit AUTO_LOAD   = 1'b0
) (
    input  logic                   CLOCK_50,
    input  logic                   RESET,
    input  logic                   DAC_CS,
    input  logic                   DAC_SCK,
    input  logic                   DAC_SDI,
    input  logic                   DAC_LD,
    output logic [c_data_bits-1:0] dac_value,
    output logic                   dac_buf,
    output logic                   dac_gain1x,
    output logic                   dac_shdn,
    output logic                   dac_valid,
    output logic                   frame_err
);

    localparam int c_pin_cs  = 0;
    localparam int c_pin_sck = 1;
    localparam int c_pin_sdi = 2;
    localparam int c_pin_ld  = 3;

    logic [3:0] w_pins, w_level, w_rise, w_fall;
    assign w_pins = {DAC_LD, DAC_SDI, DAC_SCK, DAC_CS};

    for (genvar gi = 0; gi < 4; gi++) begin : g_sync
        spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk     (CLOCK_50),
            .rst     (RESET),
            .i_pin   (w_pins[gi]),
            .o_level (w_level[gi]),
            .o_rise  (w_rise[gi]),
            .o_fall  (w_fall[gi])
        );
    end

    logic w_cs_rise, w_cs_fall, w_sck_rise, w_sdi, w_ld_fall;
    assign w_cs_rise  = w_rise[c_pin_cs];
    assign w_cs_fall  = w_fall[c_pin_cs];
    assign w_sck_rise = w_rise[c_pin_sck];
    assign w_sdi      = w_level[c_pin_sdi];
    assign w_ld_fall  = w_fall[c_pin_ld];

    state_t                  r_state,   w_state_nxt;
    logic [c_frame_bits-1:0] r_shift,   w_shift_nxt;
    logic [c_cnt_bits-1:0]   r_count,   w_count_nxt;
    logic                    r_overrun, w_overrun_nxt;
    logic                    r_pending, w_pending_nxt;
    dac_cfg_t                r_hold,    w_hold_nxt;
    dac_cfg_t                r_out,     w_out_nxt;
    logic                    r_valid,   w_valid_nxt;
    logic                    r_err,     w_err_nxt;
    logic                    w_good;
    dac_cfg_t                w_frame_cfg;

    assign w_frame_cfg = decode_frame(r_shift[c_buf:c_data_lsb]);

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_count_nxt   = r_count;
        w_overrun_nxt = r_overrun;
        w_pending_nxt = r_pending;
        w_hold_nxt    = r_hold;
        w_out_nxt     = r_out;
        w_valid_nxt   = 1'b0;
        w_err_nxt     = 1'b0;
        w_good        = 1'b0;

        // CS edges take priority so a coincident SCK edge is dropped.
        unique case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_shift_nxt   = '0;
                    w_count_nxt   = '0;
                    w_overrun_nxt = 1'b0;
                    w_state_nxt   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_cs_rise) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_sck_rise) begin
                    w_shift_nxt = {r_shift[c_frame_bits-2:0], w_sdi};
                    w_count_nxt = r_count + c_cnt_bits'(1);
                    if (r_count == c_cnt_bits'(c_frame_bits - 1)) begin
                        w_state_nxt = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                if (w_cs_rise) begin
                    if (r_overrun || r_shift[c_wr_n]) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_good = 1'b1;
                    end
                    w_state_nxt = ST_IDLE;
                end else if (w_sck_rise) begin
                    w_overrun_nxt = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (AUTO_LOAD) begin
            if (w_good) begin
                w_out_nxt   = w_frame_cfg;
                w_valid_nxt = 1'b1;
            end
        end else begin
            if (w_good) begin
                w_hold_nxt    = w_frame_cfg;
                w_pending_nxt = 1'b1;
            end
            // A load coinciding with frame end takes the frame that is just completing.
            if (w_ld_fall && (w_good || r_pending)) begin
                w_out_nxt     = w_good ? w_frame_cfg : r_hold;
                w_valid_nxt   = 1'b1;
                w_pending_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
            r_pending <= 1'b0;
            r_hold    <= c_cfg_reset;
            r_out     <= c_cfg_reset;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_count   <= w_count_nxt;
            r_overrun <= w_overrun_nxt;
            r_pending <= w_pending_nxt;
            r_hold    <= w_hold_nxt;
            r_out     <= w_out_nxt;
            r_valid   <= w_valid_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign dac_value  = r_out.value;
    assign dac_buf    = r_out.buffered;
    assign dac_gain1x = r_out.gain1x;
    assign dac_shdn   = r_out.shdn;
    assign dac_valid  = r_valid;
    assign frame_err  = r_err;

    logic w_unused;
    assign w_unused = ^{w_level[c_pin_cs], w_level[c_pin_sck], w_level[c_pin_ld],
                        w_rise[c_pin_sdi], w_rise[c_pin_ld], w_fall[c_pin_sck],
                        w_fall[c_pin_sdi], r_shift[c_data_lsb-1:0]};

endmodule
`default_nettype wire
